// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Two's complement conditional negation: result = neg ? -value : value.
module cond_negate #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] value,
  input  logic         neg,
  output logic [N-1:0] result
);

  always_comb begin
    result = neg ? (~value + N'(1)) : value;
  end

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, one partial-product add per cycle, with
// valid/ready handshakes and optional two's complement mode.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t             state;
  logic               neg_q;
  logic [WIDTH-1:0]   mag_a_q;
  // Upper half is the running partial sum, lower half the shifting multiplier.
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  logic               mode_in;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_signed;

  always_comb begin
    mode_in  = is_signed & SIGNED_EN;
    addend   = acc_q[0] ? mag_a_q : '0;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_next = {sum, acc_q[WIDTH-1:1]};
  end

  cond_negate #(.N(WIDTH)) u_neg_a (
    .value  (a),
    .neg    (mode_in & a[WIDTH-1]),
    .result (mag_a_in)
  );

  cond_negate #(.N(WIDTH)) u_neg_b (
    .value  (b),
    .neg    (mode_in & b[WIDTH-1]),
    .result (mag_b_in)
  );

  // Negation is applied to the final iteration's value so the product is
  // registered on the same edge as the DONE transition.
  cond_negate #(.N(2*WIDTH)) u_neg_p (
    .value  (acc_next),
    .neg    (neg_q),
    .result (prod_signed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      neg_q     <= 1'b0;
      mag_a_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            neg_q    <= mode_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            mag_a_q  <= mag_a_in;
            acc_q    <= {{WIDTH{1'b0}}, mag_b_in};
            cnt_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            product   <= prod_signed;
            out_valid <= 1'b1;
            state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
